// File: rtl/parking_gate_ctrl.sv
// Car-park entry gate sequencer: password check, wrong-attempt lockout,
// gate open/timeout handling and lot occupancy tracking against capacity.
module parking_gate_ctrl #(
    parameter int                     PW_WIDTH     = 4,
    parameter logic [PW_WIDTH-1:0]    PASSWORD     = 4'b0001,
    parameter int                     MAX_TRIES    = 3,
    parameter int                     LOCK_CYCLES  = 16,
    parameter int                     GATE_TIMEOUT = 32,
    parameter int                     CAPACITY     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                front_sensor,
    input  logic                back_sensor,
    input  logic                exit_sensor,
    input  logic                pw_valid,
    input  logic [PW_WIDTH-1:0] pw,
    output logic                gate_open,
    output logic                green_led,
    output logic                red_led,
    output logic                alarm,
    output logic [3:0]          occupancy,
    output logic                full
);

    // One shared timer covers both the lockout and the open-gate timeout.
    localparam int TMAX = (LOCK_CYCLES > GATE_TIMEOUT) ? LOCK_CYCLES : GATE_TIMEOUT;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LAST = TW'(GATE_TIMEOUT - 1);
    localparam logic [2:0]    TRIES_MAX = 3'(MAX_TRIES);
    localparam logic [3:0]    CAP       = 4'(CAPACITY);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_PW = 3'd1,
        ST_OPEN    = 3'd2,
        ST_PASSING = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [2:0]    tries_r;
    logic [2:0]    tries_nxt_s;
    logic [2:0]    tries_inc_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_nxt_s;
    logic [3:0]    occupancy_r;
    logic [3:0]    occupancy_nxt_s;
    logic          full_s;
    logic          pw_match_s;
    logic          wrong_nxt_s;
    logic          blocked_nxt_s;
    logic          car_in_s;
    logic          gate_r;
    logic          green_r;
    logic          red_r;
    logic          alarm_r;

    assign full_s      = (occupancy_r == CAP);
    assign pw_match_s  = (pw == PASSWORD);
    assign tries_inc_s = tries_r + 3'd1;

    // Next-state, counter updates and red-LED causes for the gate FSM.
    always_comb begin
        state_nxt_s   = state_r;
        tries_nxt_s   = tries_r;
        timer_nxt_s   = timer_r;
        wrong_nxt_s   = 1'b0;
        blocked_nxt_s = 1'b0;
        car_in_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (front_sensor && !full_s) begin
                    state_nxt_s = ST_WAIT_PW;
                    tries_nxt_s = 3'd0;
                    timer_nxt_s = '0;
                end else if (front_sensor) begin
                    blocked_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_PW: begin
                // A departing car abandons any password strobed in the same cycle.
                if (!front_sensor) begin
                    state_nxt_s = ST_IDLE;
                    tries_nxt_s = 3'd0;
                end else if (pw_valid && pw_match_s) begin
                    state_nxt_s = ST_OPEN;
                    tries_nxt_s = 3'd0;
                    timer_nxt_s = '0;
                end else if (pw_valid) begin
                    wrong_nxt_s = 1'b1;
                    tries_nxt_s = tries_inc_s;
                    if (tries_inc_s == TRIES_MAX) begin
                        state_nxt_s = ST_LOCKOUT;
                        timer_nxt_s = '0;
                    end else begin
                        state_nxt_s = ST_WAIT_PW;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_PW;
                end
            end
            ST_OPEN: begin
                if (back_sensor) begin
                    state_nxt_s = ST_PASSING;
                end else if (timer_r == GATE_LAST) begin
                    state_nxt_s = ST_IDLE;
                    timer_nxt_s = '0;
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            ST_PASSING: begin
                if (!back_sensor) begin
                    state_nxt_s = ST_IDLE;
                    car_in_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_PASSING;
                end
            end
            ST_LOCKOUT: begin
                if (timer_r == LOCK_LAST) begin
                    state_nxt_s = ST_IDLE;
                    tries_nxt_s = 3'd0;
                    timer_nxt_s = '0;
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                tries_nxt_s = 3'd0;
                timer_nxt_s = '0;
            end
        endcase
    end

    // Occupancy: saturating entry/exit count; simultaneous events cancel.
    always_comb begin
        occupancy_nxt_s = occupancy_r;
        if (car_in_s && !exit_sensor) begin
            occupancy_nxt_s = (occupancy_r == CAP) ? occupancy_r : occupancy_r + 4'd1;
        end else if (exit_sensor && !car_in_s) begin
            occupancy_nxt_s = (occupancy_r == 4'd0) ? occupancy_r : occupancy_r - 4'd1;
        end else begin
            occupancy_nxt_s = occupancy_r;
        end
    end

    // State, counters and the registered actuator/LED drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            tries_r     <= 3'd0;
            timer_r     <= '0;
            occupancy_r <= 4'd0;
            gate_r      <= 1'b0;
            green_r     <= 1'b0;
            red_r       <= 1'b0;
            alarm_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            tries_r     <= tries_nxt_s;
            timer_r     <= timer_nxt_s;
            occupancy_r <= occupancy_nxt_s;
            gate_r      <= (state_nxt_s == ST_OPEN) || (state_nxt_s == ST_PASSING);
            green_r     <= (state_nxt_s == ST_OPEN) || (state_nxt_s == ST_PASSING);
            red_r       <= wrong_nxt_s || blocked_nxt_s;
            alarm_r     <= (state_nxt_s == ST_LOCKOUT);
        end
    end

    assign gate_open = gate_r;
    assign green_led = green_r;
    assign red_led   = red_r;
    assign alarm     = alarm_r;
    assign occupancy = occupancy_r;
    assign full      = full_s;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: directed vectors push expected
// outputs; a monitor pops and compares after each clock edge or reset drop.
module tb_parking_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       front_sensor, back_sensor, exit_sensor, pw_valid;
    logic [3:0] pw;
    logic       gate_open, green_led, red_led, alarm, full;
    logic [3:0] occupancy;

    typedef struct {
        logic       g;
        logic       gr;
        logic       r;
        logic       a;
        logic [3:0] occ;
        logic       f;
        string      name;
    } exp_t;

    exp_t q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    parking_gate_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .front_sensor (front_sensor),
        .back_sensor  (back_sensor),
        .exit_sensor  (exit_sensor),
        .pw_valid     (pw_valid),
        .pw           (pw),
        .gate_open    (gate_open),
        .green_led    (green_led),
        .red_led      (red_led),
        .alarm        (alarm),
        .occupancy    (occupancy),
        .full         (full)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic eg, egr, er, ea, input logic [3:0] eo, input string nm);
        exp_t e;
        e.g = eg; e.gr = egr; e.r = er; e.a = ea; e.occ = eo;
        e.f = (eo == 4'd8);
        e.name = nm;
        q.push_back(e);
    endtask

    // One clock of stimulus plus the outputs expected after its edge.
    task automatic cyc(input logic fs, bs, ex, pv, input logic [3:0] p,
                       input logic eg, egr, er, ea, input logic [3:0] eo, input string nm);
        @(negedge clk);
        front_sensor = fs; back_sensor = bs; exit_sensor = ex;
        pw_valid = pv; pw = p;
        push_exp(eg, egr, er, ea, eo, nm);
    endtask

    task automatic car(input logic [3:0] occ0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, occ0, "car_wait");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, occ0, "car_open");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, occ0, "car_pass");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, occ0 + 4'd1, "car_in");
    endtask

    // Monitor: compares the oldest expectation against the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total_cnt++;
                if (gate_open === e.g && green_led === e.gr && red_led === e.r &&
                    alarm === e.a && occupancy === e.occ && full === e.f) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL %s: got gate=%b green=%b red=%b alarm=%b occ=%0d full=%b, want gate=%b green=%b red=%b alarm=%b occ=%0d full=%b",
                             e.name, gate_open, green_led, red_led, alarm, occupancy, full,
                             e.g, e.gr, e.r, e.a, e.occ, e.f);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        front_sensor = 1'b0; back_sensor = 1'b0; exit_sensor = 1'b0;
        pw_valid = 1'b0; pw = 4'd0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Normal entry with correct password.
        car(4'd0);

        // Three wrong passwords, then a 16-cycle lockout that ignores a correct pw.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,    1'b0, 1'b0, 1'b0, 1'b0, 4'd1, "wp_wait");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, "wrong1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,    1'b0, 1'b0, 1'b0, 1'b0, 4'd1, "red_pulse1");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, "wrong2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,    1'b0, 1'b0, 1'b0, 1'b0, 4'd1, "red_pulse2");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, "wrong3_lock");
        for (int i = 0; i < 15; i++)
            cyc(1'b1, 1'b0, 1'b0, (i == 3), 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, "lockout_hold");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, "lock_exit");

        // Tries cleared: two wrong entries must not lock; front_sensor beats pw_valid.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,    1'b0, 1'b0, 1'b0, 1'b0, 4'd1, "tc_wait");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, "tc_wrong1");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, "tc_wrong2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,    1'b0, 1'b0, 1'b0, 1'b0, 4'd1, "tries_cleared");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, "front_wins");

        // Gate timeout: open for exactly 32 cycles, pw ignored while open.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,    1'b0, 1'b0, 1'b0, 1'b0, 4'd1, "to_wait");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, "to_open");
        for (int i = 0; i < 31; i++)
            cyc(1'b0, 1'b0, 1'b0, (i == 5), 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, "open_hold");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, "timeout_close");

        // Fill to capacity, blocked entry, exit frees a slot.
        for (int k = 1; k < 8; k++)
            car(4'(k));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,    1'b0, 1'b0, 1'b1, 1'b0, 4'd8, "full_block");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, "full_block_pw");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,    1'b0, 1'b0, 1'b0, 1'b0, 4'd7, "exit_unfull");
        car(4'd7);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(7 - i), "exit_dec");

        // Exit coincident with entry, then drain to zero and saturate.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,    1'b0, 1'b0, 1'b0, 1'b0, 4'd5, "co_wait");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, "co_open");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,    1'b1, 1'b1, 1'b0, 1'b0, 4'd5, "co_pass");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,    1'b0, 1'b0, 1'b0, 1'b0, 4'd5, "exit_with_entry");
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(4 - i), "drain");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "exit_sat0");

        // Asynchronous reset while a car is passing.
        car(4'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,    1'b0, 1'b0, 1'b0, 1'b0, 4'd1, "ar_wait");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, "ar_open");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,    1'b1, 1'b1, 1'b0, 1'b0, 4'd1, "ar_pass");
        @(negedge clk);
        #2;
        push_exp(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "async_rst");
        rst_n = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,    1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "post_rst_wait");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "post_rst_open");

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
